cpu_mem_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the fetch stage (`pcF`/`instrF`) and the memory stage (`aluoutM`/`sel`/`writedataM`/`temp_readdataM`), with one transaction in flight at a time. Holds each side's returned word until the pipeline advances, and produces the stall request the hazard unit ORs into `stallF`…`stallW`. It sits between `datapath` and the external memory interface.

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/bus_hold_reg.sv | 65 ++++++
 rtl/cpu_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
//   Shared definitions for the CPU memory-port arbiter: the bus FSM state
//   encoding, the transaction owner encoding and a small helper deciding
//   whether a pipeline side still needs the bus.
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } bus_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Instruction fetches always read a full word.
  localparam logic [3:0] SEL_WORD = 4'hF;

  // A side needs the bus while it requests and has no held word yet.
  function automatic logic side_pending(input logic req, input logic rdy);
    return req & ~rdy;
  endfunction

endpackage

// File: rtl/bus_hold_reg.sv
// ---------------------------------------------------------------------------
// bus_hold_reg
//   Holds one pipeline side's completion flag and returned word until the
//   pipeline advances.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     set       : the bus transaction owned by this side completes
//     clr       : pipeline advance or exception flush
//     cancel    : the completing transaction was flushed; drop it
//     capture   : load d into rdata on set (low for stores)
//     d         : returned bus word
//     rdy       : held word valid
//     rdata     : held word
// ---------------------------------------------------------------------------
module bus_hold_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        clr,
  input  logic        cancel,
  input  logic        capture,
  input  logic [31:0] d,
  output logic        rdy,
  output logic [31:0] rdata
);

  logic        rdy_q;
  logic        rdy_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Next-state: a live completion wins over a clear; a cancelled one is
  // ignored so a simultaneous clear takes effect.
  always_comb begin
    rdy_d   = rdy_q;
    rdata_d = rdata_q;
    if (set && !cancel) begin
      rdy_d = 1'b1;
      if (capture) begin
        rdata_d = d;
      end else begin
        rdata_d = rdata_q;
      end
    end else if (clr) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
  end

  // Hold register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdy   = rdy_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
//   Shares one SRAM-like memory port between instruction fetch and the
//   M-stage load/store, one transaction at a time. Returned words are held
//   per side until the pipeline advances; mem_stall asks the hazard unit to
//   freeze the pipeline while a requesting side has no word yet.
//   Ports:
//     clk, rst                     : clock, asynchronous active-high reset
//     inst_req/inst_addr           : fetch request and word address
//     inst_rdata                   : held instruction word
//     data_req/wr/sel/addr/wdata   : M-stage access
//     data_rdata                   : held load data
//     adv                          : pipeline advances this cycle
//     flush                        : exception flush
//     mem_stall                    : stall request (combinational)
//     mem_req/wr/sel/addr/wdata    : bus request (registered)
//     mem_addr_ok/data_ok/rdata    : bus handshakes and response data
// ---------------------------------------------------------------------------
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic        adv,
  input  logic        flush,
  output logic        mem_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  bus_state_e  state_q;
  bus_state_e  state_d;
  logic        owner_q;
  logic        owner_d;
  logic        cancel_q;
  logic        cancel_d;
  logic        mem_req_q;
  logic        mem_req_d;
  logic        mem_wr_q;
  logic        mem_wr_d;
  logic [3:0]  mem_sel_q;
  logic [3:0]  mem_sel_d;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_q;
  logic [31:0] mem_wdata_d;

  logic        done_s;
  logic        inst_rdy_s;
  logic        data_rdy_s;
  logic        inst_pend_s;
  logic        data_pend_s;
  logic        drop_s;
  logic        clr_s;

  assign inst_pend_s = side_pending(inst_req, inst_rdy_s);
  assign data_pend_s = side_pending(data_req, data_rdy_s);

  // Purely from requests and held flags; no path from the bus inputs.
  assign mem_stall = inst_pend_s | data_pend_s;

  // A flush arriving on the completing edge discards that result too.
  assign drop_s = cancel_q | flush;
  assign clr_s  = adv | flush;

  // Next-state and bus request logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cancel_d    = cancel_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        // The M-stage access is older than the fetch, so it goes first.
        if (data_pend_s) begin
          state_d     = ST_ADDR;
          owner_d     = OWN_DATA;
          mem_req_d   = 1'b1;
          mem_wr_d    = data_wr;
          mem_sel_d   = data_sel;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
        end else if (inst_pend_s) begin
          state_d     = ST_ADDR;
          owner_d     = OWN_INST;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_sel_d   = SEL_WORD;
          mem_addr_d  = inst_addr;
          mem_wdata_d = 32'h0000_0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (flush) begin
          cancel_d = 1'b1;
        end else begin
          cancel_d = cancel_q;
        end
        if (mem_addr_ok) begin
          state_d   = ST_DATA;
          mem_req_d = 1'b0;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        // Always return to IDLE; a waiting request is issued from there.
        if (mem_data_ok) begin
          state_d  = ST_IDLE;
          cancel_d = 1'b0;
          done_s   = 1'b1;
        end else if (flush) begin
          cancel_d = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cancel_d  = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and bus output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_INST;
      cancel_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_sel_q   <= 4'h0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cancel_q    <= cancel_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  bus_hold_reg u_inst_hold (
    .clk     (clk),
    .rst     (rst),
    .set     (done_s & (owner_q == OWN_INST)),
    .clr     (clr_s),
    .cancel  (drop_s),
    .capture (1'b1),
    .d       (mem_rdata),
    .rdy     (inst_rdy_s),
    .rdata   (inst_rdata)
  );

  // Stores only report completion; the held load word is left untouched.
  bus_hold_reg u_data_hold (
    .clk     (clk),
    .rst     (rst),
    .set     (done_s & (owner_q == OWN_DATA)),
    .clr     (clr_s),
    .cancel  (drop_s),
    .capture (~mem_wr_q),
    .d       (mem_rdata),
    .rdy     (data_rdy_s),
    .rdata   (data_rdata)
  );

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model (one in-flight bus transfer record plus per-side held words) drives
//   the memory responses and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        adv;
  logic        flush;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  cpu_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_sel    (data_sel),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .adv         (adv),
    .flush       (flush),
    .mem_stall   (mem_stall),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Staged CPU-side inputs, applied at the next falling edge.
  logic        s_rst;
  logic        s_inst_req;
  logic [31:0] s_inst_addr;
  logic        s_data_req;
  logic        s_data_wr;
  logic [3:0]  s_data_sel;
  logic [31:0] s_data_addr;
  logic [31:0] s_data_wdata;
  logic        s_adv;
  logic        s_flush;

  // Memory latency settings.
  logic rand_dly;
  int   acc_dly;
  int   dat_dly;

  // Model: held words per side and the single in-flight transfer.
  logic        m_inst_rdy;
  logic        m_data_rdy;
  logic [31:0] m_inst_rdata;
  logic [31:0] m_data_rdata;
  logic        m_act;
  logic        m_acc;
  logic        m_cancel;
  logic        m_own_data;
  logic        m_wr;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_acnt;
  int          m_dcnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'hBFC0_0000: w = 32'h3C08_0001;
      32'h8000_0020: w = 32'hDEAD_BEEF;
      default:       w = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_inst_rdy   = 1'b0;
    m_data_rdy   = 1'b0;
    m_inst_rdata = 32'h0;
    m_data_rdata = 32'h0;
    m_act        = 1'b0;
    m_acc        = 1'b0;
    m_cancel     = 1'b0;
    m_own_data   = 1'b0;
    m_wr         = 1'b0;
    m_sel        = 4'h0;
    m_addr       = 32'h0;
    m_wdata      = 32'h0;
    m_acnt       = 0;
    m_dcnt       = 0;
  endtask

  function automatic logic staged_stall();
    return (s_inst_req & ~m_inst_rdy) | (s_data_req & ~m_data_rdy);
  endfunction

  // Advance the model by one clock edge using this cycle's inputs.
  task automatic model_update();
    logic ip;
    logic dp;
    logic done;
    logic drop;
    if (rst) begin
      m_reset();
      return;
    end
    ip   = inst_req & ~m_inst_rdy;
    dp   = data_req & ~m_data_rdy;
    done = m_act & m_acc & mem_data_ok;
    drop = m_cancel | flush;
    if (done && !m_own_data && !drop) begin
      m_inst_rdy   = 1'b1;
      m_inst_rdata = mem_rdata;
    end else if (adv || flush) begin
      m_inst_rdy = 1'b0;
    end
    if (done && m_own_data && !drop) begin
      m_data_rdy = 1'b1;
      if (!m_wr) m_data_rdata = mem_rdata;
    end else if (adv || flush) begin
      m_data_rdy = 1'b0;
    end
    if (!m_act) begin
      m_cancel = 1'b0;
      if (dp || ip) begin
        m_act      = 1'b1;
        m_acc      = 1'b0;
        m_own_data = dp;
        m_wr       = dp ? data_wr : 1'b0;
        m_sel      = dp ? data_sel : 4'hF;
        m_addr     = dp ? data_addr : inst_addr;
        m_wdata    = data_wdata;
        m_acnt     = rand_dly ? int'($urandom_range(0, 2)) : acc_dly;
      end
    end else if (!m_acc) begin
      if (flush) m_cancel = 1'b1;
      if (mem_addr_ok) begin
        m_acc  = 1'b1;
        m_dcnt = rand_dly ? int'($urandom_range(0, 3)) : dat_dly;
      end else begin
        m_acnt--;
      end
    end else begin
      if (mem_data_ok) begin
        m_act    = 1'b0;
        m_cancel = 1'b0;
      end else begin
        if (flush) m_cancel = 1'b1;
        m_dcnt--;
      end
    end
  endtask

  task automatic compare_outputs();
    logic exp_req;
    chk("mem_stall", 32'(mem_stall),
        32'((inst_req & ~m_inst_rdy) | (data_req & ~m_data_rdy)));
    exp_req = m_act & ~m_acc;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wr", 32'(mem_wr), 32'(m_wr));
      chk("mem_sel", 32'(mem_sel), 32'(m_sel));
      if (m_own_data) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("inst_rdata", inst_rdata, m_inst_rdata);
    chk("data_rdata", data_rdata, m_data_rdata);
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    rst         = s_rst;
    inst_req    = s_inst_req;
    inst_addr   = s_inst_addr;
    data_req    = s_data_req;
    data_wr     = s_data_wr;
    data_sel    = s_data_sel;
    data_addr   = s_data_addr;
    data_wdata  = s_data_wdata;
    adv         = s_adv;
    flush       = s_flush;
    mem_addr_ok = m_act & ~m_acc & (m_acnt == 0);
    mem_data_ok = m_act & m_acc & (m_dcnt == 0);
    mem_rdata   = mem_data_ok ? mem_word(m_addr) : $urandom();
    #1;
    compare_outputs();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc();
    begin_cycle();
    end_cycle();
  endtask

  task automatic clear_stage();
    s_inst_req   = 1'b0;
    s_inst_addr  = 32'h0;
    s_data_req   = 1'b0;
    s_data_wr    = 1'b0;
    s_data_sel   = 4'h0;
    s_data_addr  = 32'h0;
    s_data_wdata = 32'h0;
    s_adv        = 1'b0;
    s_flush      = 1'b0;
  endtask

  // Run until every staged request is served, then advance and go quiet.
  task automatic drain();
    int n;
    n = 0;
    s_adv   = 1'b0;
    s_flush = 1'b0;
    while (staged_stall() && n < 60) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: still stalled after %0d cycles, required completion", n);
    end
    s_adv = 1'b1;
    cyc();
    clear_stage();
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic need_new;
    rst = 1'b1;
    s_rst = 1'b1;
    clear_stage();
    rand_dly = 1'b0;
    acc_dly = 0;
    dat_dly = 0;
    m_reset();

    // Reset state.
    begin_cycle();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_sel", 32'(mem_sel), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    end_cycle();
    cyc();
    s_rst = 1'b0;
    cyc();

    // Fetch only, zero-wait.
    s_inst_req = 1'b1; s_inst_addr = 32'hBFC0_0000;
    begin_cycle(); chk("t1_c0_stall", 32'(mem_stall), 32'h1); chk("t1_c0_req", 32'(mem_req), 32'h0); end_cycle();
    begin_cycle(); chk("t1_c1_req", 32'(mem_req), 32'h1); chk("t1_c1_addr", mem_addr, 32'hBFC0_0000);
    chk("t1_c1_sel", 32'(mem_sel), 32'hF); end_cycle();
    begin_cycle(); chk("t1_c2_req", 32'(mem_req), 32'h0); chk("t1_c2_stall", 32'(mem_stall), 32'h1); end_cycle();
    s_adv = 1'b1;
    begin_cycle(); chk("t1_c3_rdata", inst_rdata, 32'h3C08_0001); chk("t1_c3_stall", 32'(mem_stall), 32'h0); end_cycle();
    clear_stage(); cyc();

    // Store and fetch pending together.
    s_data_req = 1'b1; s_data_wr = 1'b1; s_data_sel = 4'b0011;
    s_data_addr = 32'h8000_0010; s_data_wdata = 32'h0000_BEEF;
    s_inst_req = 1'b1; s_inst_addr = 32'hBFC0_0004;
    cyc();
    begin_cycle(); chk("t2_c1_req", 32'(mem_req), 32'h1); chk("t2_c1_wr", 32'(mem_wr), 32'h1);
    chk("t2_c1_sel", 32'(mem_sel), 32'h3); chk("t2_c1_addr", mem_addr, 32'h8000_0010);
    chk("t2_c1_wdata", mem_wdata, 32'h0000_BEEF); end_cycle();
    cyc();
    begin_cycle(); chk("t2_c3_stall", 32'(mem_stall), 32'h1); chk("t2_c3_req", 32'(mem_req), 32'h0); end_cycle();
    begin_cycle(); chk("t2_c4_req", 32'(mem_req), 32'h1); chk("t2_c4_addr", mem_addr, 32'hBFC0_0004);
    chk("t2_c4_wr", 32'(mem_wr), 32'h0); end_cycle();
    begin_cycle(); chk("t2_c5_stall", 32'(mem_stall), 32'h1); end_cycle();
    s_adv = 1'b1;
    begin_cycle(); chk("t2_c6_stall", 32'(mem_stall), 32'h0); end_cycle();
    clear_stage(); cyc();

    // Slow memory: addr_ok after 2 waits, data_ok 3 cycles later.
    acc_dly = 2; dat_dly = 2;
    s_data_req = 1'b1; s_data_wr = 1'b0; s_data_sel = 4'hF;
    s_data_addr = 32'h8000_0040; s_data_wdata = 32'h1234_5678;
    cyc();
    for (int i = 1; i <= 3; i++) begin
      begin_cycle();
      chk("t3_addr_req", 32'(mem_req), 32'h1);
      chk("t3_addr_addr", mem_addr, 32'h8000_0040);
      chk("t3_addr_wdata", mem_wdata, 32'h1234_5678);
      chk("t3_addr_sel", 32'(mem_sel), 32'hF);
      end_cycle();
      s_data_addr = 32'h8000_0099; s_data_wdata = 32'h0;
    end
    begin_cycle(); chk("t3_c4_req", 32'(mem_req), 32'h0); end_cycle();
    cyc(); cyc();
    s_adv = 1'b1;
    begin_cycle(); chk("t3_c7_rdata", data_rdata, 32'h1317_E420); chk("t3_c7_stall", 32'(mem_stall), 32'h0); end_cycle();
    clear_stage(); cyc();

    // Flush one cycle after a load enters DATA.
    acc_dly = 0; dat_dly = 2;
    s_data_req = 1'b1; s_data_sel = 4'hF; s_data_addr = 32'h8000_0020;
    cyc(); cyc(); cyc();
    s_flush = 1'b1; s_data_req = 1'b0;
    cyc();
    s_flush = 1'b0;
    cyc();
    dat_dly = 0;
    s_inst_req = 1'b1; s_inst_addr = 32'hBFC0_0380;
    begin_cycle(); chk("t4_c5_req", 32'(mem_req), 32'h0); chk("t4_c5_rdata", data_rdata, 32'h1317_E420); end_cycle();
    begin_cycle(); chk("t4_c6_req", 32'(mem_req), 32'h1); chk("t4_c6_addr", mem_addr, 32'hBFC0_0380); end_cycle();
    cyc();
    s_data_req = 1'b1;
    begin_cycle(); chk("t4_c8_inst", inst_rdata, 32'h10D7_DBE0); chk("t4_c8_stall", 32'(mem_stall), 32'h1);
    chk("t4_c8_drdata", data_rdata, 32'h1317_E420); end_cycle();
    drain();

    // Reset asserted while a fetch is in DATA.
    dat_dly = 3;
    s_data_req = 1'b1; s_data_addr = 32'h8000_0044; s_data_sel = 4'hF;
    s_inst_req = 1'b1; s_inst_addr = 32'hBFC0_0010;
    for (int i = 0; i < 8; i++) cyc();
    begin_cycle();
    chk("t5_pre_rdata", data_rdata, 32'h1313_E420);
    rst = 1'b1;
    #1;
    chk("t5_rst_req", 32'(mem_req), 32'h0);
    chk("t5_rst_irdata", inst_rdata, 32'h0);
    chk("t5_rst_drdata", data_rdata, 32'h0);
    chk("t5_rst_stall", 32'(mem_stall), 32'h1);
    m_reset();
    end_cycle();
    clear_stage(); cyc(); cyc();

    // adv held low for 5 cycles after rdy rises.
    dat_dly = 0;
    s_inst_req = 1'b1; s_inst_addr = 32'hBFC0_0000;
    cyc(); cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      chk("t6_hold_rdata", inst_rdata, 32'h3C08_0001);
      chk("t6_hold_req", 32'(mem_req), 32'h0);
      chk("t6_hold_stall", 32'(mem_stall), 32'h0);
      end_cycle();
    end
    s_adv = 1'b1;
    cyc();
    s_adv = 1'b0; s_inst_addr = 32'hBFC0_0004;
    begin_cycle(); chk("t6_after_adv_stall", 32'(mem_stall), 32'h1); end_cycle();
    drain();

    // Randomized traffic.
    rand_dly = 1'b1;
    need_new = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (need_new) begin
        s_inst_req   = ($urandom_range(0, 3) != 0);
        s_inst_addr  = {$urandom(), 2'b00} ;
        s_data_req   = ($urandom_range(0, 2) == 0);
        s_data_wr    = $urandom_range(0, 1) == 1;
        s_data_sel   = 4'($urandom_range(1, 15));
        s_data_addr  = $urandom();
        s_data_wdata = $urandom();
      end
      s_flush = ($urandom_range(0, 49) == 0);
      s_adv   = !staged_stall() && ($urandom_range(0, 3) != 0);
      cyc();
      need_new = s_adv | s_flush;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
